strob_word_tx: RTL and testbench
================================

// Module: strob_word_tx
// PURPOSE
//  Consumes the one-cycle write strobe (strob_main) from the strobe delay/edge stage.
//  On each strobe it captures the parallel write word into a small FIFO.
//  It then serialises each word onto a single line: start bit, data MSB-first,
//  odd parity, stop bit. Sits between the write-strobe conditioner and the line driver.
// PARAMETERS
//  DATA_W      16  width of captured write word
//  FIFO_DEPTH  4   words buffered (power of 2, >=2)
//  BIT_DIV     8   CLK cycles per serial bit (>=1)
// PORTS
//  CLK         in   1                     system clock, all logic on rising edge
//  CLR_n       in   1                     reset, synchronous, active-low
//  strob_main  in   1                     one-cycle write strobe; capture data_WR this cycle
//  data_WR     in   DATA_W                write word, valid when strob_main=1
//  tx_out      out  1                     serial line, idle high
//  tx_busy     out  1                     1 while a frame is on the line (START..STOP)
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  words waiting (not incl. word in shifter)
//  fifo_full   out  1                     fifo_count==FIFO_DEPTH
//  fifo_empty  out  1                     fifo_count==0
//  overflow    out  1                     sticky: a strobe was dropped; cleared only by reset
// BEHAVIOUR
//  Reset (CLR_n=0 at edge): tx_out=1, tx_busy=0, fifo_count=0, fifo_empty=1,
//   fifo_full=0, overflow=0, FSM=IDLE, bit/div counters=0. Applies mid-frame too:
//   line returns high on the next edge; queued words are discarded.
//  Capture: strob_main=1 at edge n -> word in FIFO, fifo_count visible +1 after edge n.
//   Push accepted if count<FIFO_DEPTH, or if the FSM pops in the same cycle.
//   Otherwise the word is dropped, count is unchanged, and overflow is set after edge n.
//   strob_main held high for k cycles = k pushes (no edge detect here).
//  FSM states: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state lasts BIT_DIV cycles
//   (div counter 0..BIT_DIV-1; the state advances when div==BIT_DIV-1).
//   IDLE: tx_out=1. If !fifo_empty: pop the head into the shift reg, compute odd parity
//         (^word ^ 1'b1 inverted so total ones incl. parity is odd), go to START.
//   START: tx_out=0. DATA: tx_out=shreg[DATA_W-1], shift left per bit, DATA_W bits.
//   PARITY: tx_out=parity bit. STOP: tx_out=1.
//   STOP, last cycle: if FIFO nonempty, pop and go to START directly (no idle gap);
//         otherwise go to IDLE.
//  Latency: strobe at edge n into an empty, idle block -> pop at edge n+1,
//   tx_out=0 from edge n+2. Frame = (DATA_W+3)*BIT_DIV cycles.
//  tx_busy=1 exactly while FSM!=IDLE. The popped word no longer counts in fifo_count.
//  Simultaneous push+pop: count unchanged; order strictly FIFO; a full FIFO with pop accepts.
//  Pointers wrap modulo FIFO_DEPTH; count saturates by construction (never >DEPTH, never <0).
//  All outputs are registered except fifo_full and fifo_empty (decoded from the count register).
// STRUCTURE
//  Package strob_tx_pkg: tx_state_t enum {IDLE,START,DATA,PARITY,STOP};
//   localparams for frame-bit count (DATA_W+3) and line idle level (1'b1).
//  Sub-module word_fifo (DATA_W, FIFO_DEPTH): sync FIFO with push/pop/count/full/empty,
//   same CLK/CLR_n; push-when-full-with-pop allowed.
//  Top: serializer FSM, div counter, bit counter, shift reg, parity, overflow flag.
// TESTING (DATA_W=16, FIFO_DEPTH=4, BIT_DIV=8 unless stated)
//  1 Single strobe, data_WR=16'hA5C3 at edge n -> tx_out 0 for cycles n+2..n+9, then
//    1010_0101_1100_0011 at 8 cycles/bit, parity=1, stop=1; tx_busy low after 152 cycles.
//  2 Six strobes on consecutive cycles while idle -> 1 word in shifter, 4 queued,
//    6th dropped; overflow=1, fifo_full=1; five frames back-to-back with no idle gap.
//  3 FIFO full with FSM in STOP last cycle + strobe same cycle -> word accepted,
//    count stays 4, overflow stays 0.
//  4 CLR_n=0 for 1 cycle mid-DATA with 3 queued -> next edge tx_out=1, count=0,
//    tx_busy=0, overflow=0; a new strobe afterwards sends a clean frame.
//  5 BIT_DIV=1, data_WR=16'h0000 -> frame 19 cycles, parity bit=1; 16'h0001 -> parity=0.

Source files
------------

// File: rtl/strob_tx_pkg.sv
// Shared types and constants for the strobe-driven serial word transmitter.
// Frame layout: start, DATA_W data bits MSB-first, odd parity, stop.
package strob_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int   FRAME_EXTRA = 3;
   localparam logic LINE_IDLE   = 1'b1;

   function automatic int frame_bits(input int data_w);
      return data_w + FRAME_EXTRA;
   endfunction

endpackage

// File: rtl/strob_word_tx_if.sv
// Write-strobe input bus and serial line / FIFO status outputs.
// master drives strobe and word; slave is the transmitter.
interface strob_word_tx_if #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
);
   logic                          strob_main;
   logic [DATA_W-1:0]             data_WR;
   logic                          tx_out;
   logic                          tx_busy;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic                          overflow;

   modport master (
      output strob_main, data_WR,
      input  tx_out, tx_busy, fifo_count,
      input  fifo_full, fifo_empty, overflow
   );

   modport slave (
      input  strob_main, data_WR,
      output tx_out, tx_busy, fifo_count,
      output fifo_full, fifo_empty, overflow
   );
endinterface

// File: rtl/word_fifo.sv
// Small synchronous word FIFO with registered count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module word_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          CLR_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_W-1:0]             din,
   output logic [DATA_W-1:0]             dout,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty,
   output logic                          accept
);
   import strob_tx_pkg::*;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              pop_ok;

   assign full   = (count == CW'(FIFO_DEPTH));
   assign empty  = (count == '0);
   assign pop_ok = pop && !empty;
   assign accept = push && (!full || pop_ok);
   assign dout   = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility
   always_ff @(posedge CLK) begin
      if (accept) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and count bookkeeping; pointers wrap on power-of-2 depth
   always_ff @(posedge CLK) begin
      if (!CLR_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(accept) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/strob_word_tx.sv
// Captures words on write strobes into a FIFO and serialises them:
// start, data MSB-first, odd parity, stop; frames run back-to-back.
module strob_word_tx #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int BIT_DIV    = 8
) (
   input  logic            CLK,
   input  logic            CLR_n,
   strob_word_tx_if.slave  bus
);
   import strob_tx_pkg::*;

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int BIT_W = $clog2(frame_bits(DATA_W));

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] head;
   logic              parity;
   logic              pop;
   logic              accept;
   logic              div_last;
   logic              data_last;
   logic              line;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;

   word_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK    (CLK),
      .CLR_n  (CLR_n),
      .push   (bus.strob_main),
      .pop    (pop),
      .din    (bus.data_WR),
      .dout   (head),
      .count  (count),
      .full   (full),
      .empty  (empty),
      .accept (accept)
   );

   assign bus.fifo_count = count;
   assign bus.fifo_full  = full;
   assign bus.fifo_empty = empty;

   assign div_last  = (div_cnt == DIV_W'(BIT_DIV - 1));
   assign data_last = (bit_cnt == BIT_W'(DATA_W));

   // FSM state register
   always_ff @(posedge CLK) begin
      if (!CLR_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and pop; STOP chains straight into START when work waits
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (div_last) state_nxt = DATA;
         end
         DATA: begin
            if (div_last && data_last) state_nxt = PARITY;
         end
         PARITY: begin
            if (div_last) state_nxt = STOP;
         end
         STOP: begin
            if (div_last) begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line level for the current state, registered below
   always_comb begin
      line = LINE_IDLE;
      unique case (state)
         IDLE:    line = LINE_IDLE;
         START:   line = 1'b0;
         DATA:    line = shreg[DATA_W-1];
         PARITY:  line = parity;
         STOP:    line = LINE_IDLE;
         default: line = LINE_IDLE;
      endcase
   end

   // Bit timing, frame-bit index, shifter load/shift and parity capture
   always_ff @(posedge CLK) begin
      if (!CLR_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         parity  <= 1'b0;
      end else begin
         if (state == IDLE || div_last) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         if (pop) begin
            shreg   <= head;
            parity  <= ~^head;
            bit_cnt <= '0;
         end else if (state != IDLE && div_last) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (state == DATA) begin
               shreg <= {shreg[DATA_W-2:0], 1'b0};
            end
         end
      end
   end

   // Registered line, busy flag and sticky drop flag
   always_ff @(posedge CLK) begin
      if (!CLR_n) begin
         bus.tx_out   <= LINE_IDLE;
         bus.tx_busy  <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         bus.tx_out  <= line;
         bus.tx_busy <= (state_nxt != IDLE);
         if (bus.strob_main && !accept) begin
            bus.overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_strob_word_tx.sv
// Directed bench for strob_word_tx: BIT_DIV=8 and BIT_DIV=1 instances.
// Expected frames built from hand-computed data and parity constants.
module tb_strob_word_tx;

   logic CLK;
   logic CLR_n;
   int   checks;
   int   errors;

   strob_word_tx_if #(.DATA_W(16), .FIFO_DEPTH(4)) bus0 ();
   strob_word_tx_if #(.DATA_W(16), .FIFO_DEPTH(4)) bus1 ();

   strob_word_tx #(
      .DATA_W     (16),
      .FIFO_DEPTH (4),
      .BIT_DIV    (8)
   ) u_dut (
      .CLK   (CLK),
      .CLR_n (CLR_n),
      .bus   (bus0)
   );

   strob_word_tx #(
      .DATA_W     (16),
      .FIFO_DEPTH (4),
      .BIT_DIV    (1)
   ) u_dut1 (
      .CLK   (CLK),
      .CLR_n (CLR_n),
      .bus   (bus1)
   );

   // Free-running clock
   always #5 CLK = ~CLK;

   function automatic logic tx_of(input bit sel);
      return sel ? bus1.tx_out : bus0.tx_out;
   endfunction

   function automatic logic busy_of(input bit sel);
      return sel ? bus1.tx_busy : bus0.tx_busy;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic strobe(input bit sel, input logic [15:0] d);
      if (sel) begin
         bus1.strob_main = 1'b1;
         bus1.data_WR    = d;
      end else begin
         bus0.strob_main = 1'b1;
         bus0.data_WR    = d;
      end
      tick();
      bus0.strob_main = 1'b0;
      bus1.strob_main = 1'b0;
   endtask

   // Walk one frame starting at cycle index skip; caller sits one
   // edge before the frame's sample at index skip.
   task automatic run_frame(input bit sel, input logic [15:0] d,
                            input logic p, input int div,
                            input int skip, input bit last,
                            input string tag);
      logic [18:0] fb;
      logic        eb;
      fb = {1'b0, d, p, 1'b1};
      for (int c = skip; c < 19 * div; c++) begin
         tick();
         checks++;
         if (tx_of(sel) !== fb[18 - c / div]) begin
            errors++;
            $display("FAIL %s tx_out cyc %0d: got %b want %b",
                     tag, c, tx_of(sel), fb[18 - c / div]);
         end
         eb = (c < 19 * div - 1) ? 1'b1 : !last;
         checks++;
         if (busy_of(sel) !== eb) begin
            errors++;
            $display("FAIL %s tx_busy cyc %0d: got %b want %b",
                     tag, c, busy_of(sel), eb);
         end
      end
   endtask

   task automatic test_reset();
      CLR_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus0.tx_out !== 1'b1) begin
         errors++;
         $display("FAIL rst tx_out: got %b want 1", bus0.tx_out);
      end
      checks++;
      if (bus0.tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst tx_busy: got %b want 0", bus0.tx_busy);
      end
      checks++;
      if (bus0.fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL rst count: got %0d want 0", bus0.fifo_count);
      end
      checks++;
      if (bus0.fifo_empty !== 1'b1 || bus0.fifo_full !== 1'b0) begin
         errors++;
         $display("FAIL rst flags: empty %b full %b want 1 0",
                  bus0.fifo_empty, bus0.fifo_full);
      end
      checks++;
      if (bus0.overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst overflow: got %b want 0", bus0.overflow);
      end
      checks++;
      if (bus1.tx_out !== 1'b1 || bus1.tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst dut1: tx %b busy %b want 1 0",
                  bus1.tx_out, bus1.tx_busy);
      end
      CLR_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      strobe(0, 16'hA5C3);
      checks++;
      if (bus0.fifo_count !== 3'd1 || bus0.tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL single capture: count %0d busy %b want 1 0",
                  bus0.fifo_count, bus0.tx_busy);
      end
      tick();
      checks++;
      if (bus0.fifo_count !== 3'd0 || bus0.tx_busy !== 1'b1 ||
          bus0.tx_out !== 1'b1) begin
         errors++;
         $display("FAIL single pop: count %0d busy %b tx %b want 0 1 1",
                  bus0.fifo_count, bus0.tx_busy, bus0.tx_out);
      end
      run_frame(0, 16'hA5C3, 1'b1, 8, 0, 1, "single");
   endtask

   task automatic test_overflow_b2b();
      logic [15:0] w [6];
      logic        p [5];
      logic [2:0]  ec [6];
      w  = '{16'h1111, 16'h8001, 16'h7000, 16'hFFFE, 16'h0F0F, 16'hDEAD};
      p  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      ec = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      for (int i = 0; i < 6; i++) begin
         strobe(0, w[i]);
         checks++;
         if (bus0.fifo_count !== ec[i]) begin
            errors++;
            $display("FAIL b2b count strobe %0d: got %0d want %0d",
                     i, bus0.fifo_count, ec[i]);
         end
         checks++;
         if (bus0.overflow !== (i == 5)) begin
            errors++;
            $display("FAIL b2b overflow strobe %0d: got %b want %b",
                     i, bus0.overflow, (i == 5));
         end
      end
      checks++;
      if (bus0.fifo_full !== 1'b1) begin
         errors++;
         $display("FAIL b2b full: got %b want 1", bus0.fifo_full);
      end
      run_frame(0, w[0], p[0], 8, 4, 0, "b2b0");
      for (int i = 1; i < 5; i++) begin
         run_frame(0, w[i], p[i], 8, 0, (i == 4), "b2bN");
      end
      checks++;
      if (bus0.fifo_empty !== 1'b1 || bus0.overflow !== 1'b1) begin
         errors++;
         $display("FAIL b2b end: empty %b overflow %b want 1 1",
                  bus0.fifo_empty, bus0.overflow);
      end
   endtask

   task automatic test_reset_mid();
      strobe(0, 16'h0101);
      strobe(0, 16'h0202);
      strobe(0, 16'h0303);
      strobe(0, 16'h0404);
      repeat (20) tick();
      checks++;
      if (bus0.fifo_count !== 3'd3 || bus0.tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL mid pre: count %0d busy %b want 3 1",
                  bus0.fifo_count, bus0.tx_busy);
      end
      CLR_n = 1'b0;
      tick();
      CLR_n = 1'b1;
      checks++;
      if (bus0.tx_out !== 1'b1 || bus0.tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid rst line: tx %b busy %b want 1 0",
                  bus0.tx_out, bus0.tx_busy);
      end
      checks++;
      if (bus0.fifo_count !== 3'd0 || bus0.fifo_empty !== 1'b1) begin
         errors++;
         $display("FAIL mid rst fifo: count %0d empty %b want 0 1",
                  bus0.fifo_count, bus0.fifo_empty);
      end
      checks++;
      if (bus0.overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid rst overflow: got %b want 0", bus0.overflow);
      end
      repeat (3) tick();
      checks++;
      if (bus0.tx_busy !== 1'b0 || bus0.tx_out !== 1'b1) begin
         errors++;
         $display("FAIL mid idle: busy %b tx %b want 0 1",
                  bus0.tx_busy, bus0.tx_out);
      end
      strobe(0, 16'h1234);
      tick();
      run_frame(0, 16'h1234, 1'b0, 8, 0, 1, "mid_new");
   endtask

   task automatic test_full_pop();
      CLR_n = 1'b0;
      tick();
      tick();
      CLR_n = 1'b1;
      tick();
      strobe(0, 16'hAAAA);
      strobe(0, 16'hBBBB);
      strobe(0, 16'hCCCC);
      strobe(0, 16'hDDDD);
      strobe(0, 16'hEEEE);
      checks++;
      if (bus0.fifo_count !== 3'd4 || bus0.fifo_full !== 1'b1 ||
          bus0.overflow !== 1'b0) begin
         errors++;
         $display("FAIL full pre: count %0d full %b ovf %b want 4 1 0",
                  bus0.fifo_count, bus0.fifo_full, bus0.overflow);
      end
      repeat (148) tick();
      checks++;
      if (bus0.tx_busy !== 1'b1 || bus0.fifo_count !== 3'd4) begin
         errors++;
         $display("FAIL full stop: busy %b count %0d want 1 4",
                  bus0.tx_busy, bus0.fifo_count);
      end
      strobe(0, 16'h5555);
      checks++;
      if (bus0.fifo_count !== 3'd4 || bus0.overflow !== 1'b0) begin
         errors++;
         $display("FAIL full pop push: count %0d ovf %b want 4 0",
                  bus0.fifo_count, bus0.overflow);
      end
      checks++;
      if (bus0.tx_out !== 1'b1 || bus0.tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL full stop bit: tx %b busy %b want 1 1",
                  bus0.tx_out, bus0.tx_busy);
      end
      strobe(0, 16'h6666);
      checks++;
      if (bus0.tx_out !== 1'b0) begin
         errors++;
         $display("FAIL full no gap: tx %b want 0", bus0.tx_out);
      end
      checks++;
      if (bus0.fifo_count !== 3'd4 || bus0.overflow !== 1'b1) begin
         errors++;
         $display("FAIL full drop: count %0d ovf %b want 4 1",
                  bus0.fifo_count, bus0.overflow);
      end
   endtask

   task automatic test_div1();
      strobe(1, 16'h0000);
      tick();
      checks++;
      if (bus1.tx_busy !== 1'b1 || bus1.tx_out !== 1'b1) begin
         errors++;
         $display("FAIL div1 pop: busy %b tx %b want 1 1",
                  bus1.tx_busy, bus1.tx_out);
      end
      run_frame(1, 16'h0000, 1'b1, 1, 0, 1, "div1_0000");
      strobe(1, 16'h0001);
      tick();
      run_frame(1, 16'h0001, 1'b0, 1, 0, 1, "div1_0001");
   endtask

   initial begin
      CLK             = 1'b0;
      CLR_n           = 1'b0;
      checks          = 0;
      errors          = 0;
      bus0.strob_main = 1'b0;
      bus0.data_WR    = '0;
      bus1.strob_main = 1'b0;
      bus1.data_WR    = '0;
      test_reset();
      test_single();
      test_overflow_b2b();
      test_reset_mid();
      test_full_pop();
      test_div1();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
